// File: rtl/clock_divider.sv
// clock_divider: counter-based integer clock divider with a registered output.
// Optional CLOCK_DIVIDER_TICK_EN adds a one-cycle tick_out on each clk_out rise.
module clock_divider #(
    parameter int COUNT_REG_SIZE = 3,
    parameter int DIV_RATIO      = 4
) (
    input  logic clk,
    input  logic reset,
`ifdef CLOCK_DIVIDER_TICK_EN
    output logic tick_out,
`endif
    output logic clk_out
);

    // Low phase takes the extra cycle on odd ratios.
    localparam int LOW_CYCLES = (DIV_RATIO + 1) / 2;

    localparam logic [COUNT_REG_SIZE-1:0] LAST =
        COUNT_REG_SIZE'(DIV_RATIO - 1);
    localparam logic [COUNT_REG_SIZE-1:0] RISE =
        COUNT_REG_SIZE'(LOW_CYCLES);
    localparam logic [COUNT_REG_SIZE-1:0] ONE =
        COUNT_REG_SIZE'(1);

    // Reject ratios the counter cannot represent or that cannot toggle.
    if (DIV_RATIO < 2) begin : g_ratio_low
        $fatal(1, "clock_divider: DIV_RATIO must be >= 2");
    end
    if (DIV_RATIO > (1 << COUNT_REG_SIZE)) begin : g_ratio_high
        $fatal(1, "clock_divider: DIV_RATIO exceeds counter range");
    end

    // Declared initial values give a defined 0 before any reset edge.
    logic [COUNT_REG_SIZE-1:0] cnt_q = '0;
    logic [COUNT_REG_SIZE-1:0] cnt_d;
    logic                      clk_out_q = 1'b0;
    logic                      clk_out_d;

    // Next count wraps at DIV_RATIO-1; output level follows the next count.
    always_comb begin
        cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + ONE;
        clk_out_d = (cnt_d >= RISE);
    end

    // Counter and output flop; reset wins over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

`ifdef CLOCK_DIVIDER_TICK_EN
    logic tick_q = 1'b0;
    logic tick_d;

    // Tick marks the cycle in which clk_out has just risen.
    always_comb begin
        tick_d = (cnt_d == RISE);
    end

    // Tick flop shares the counter's reset behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_out = tick_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: directed table check of ratios 4, 5 and 8 sharing one reset.
// Expected counter/output values are hand-computed per edge.
module tb_clock_divider;

    logic clk;
    logic reset;
    logic out4, out5, out8;
`ifdef CLOCK_DIVIDER_TICK_EN
    logic tick4;
`endif

    int total = 0;
    int bad   = 0;

    clock_divider #(.COUNT_REG_SIZE(3), .DIV_RATIO(4)) dut4 (
        .clk(clk),
        .reset(reset),
`ifdef CLOCK_DIVIDER_TICK_EN
        .tick_out(tick4),
`endif
        .clk_out(out4)
    );

    clock_divider #(.COUNT_REG_SIZE(3), .DIV_RATIO(5)) dut5 (
        .clk(clk),
        .reset(reset),
`ifdef CLOCK_DIVIDER_TICK_EN
        .tick_out(),
`endif
        .clk_out(out5)
    );

    clock_divider #(.COUNT_REG_SIZE(3), .DIV_RATIO(8)) dut8 (
        .clk(clk),
        .reset(reset),
`ifdef CLOCK_DIVIDER_TICK_EN
        .tick_out(),
`endif
        .clk_out(out8)
    );

    // First rising edge at t=3, period 2.
    initial begin
        clk = 1'b0;
        #2;
        forever #1 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       o4;
        logic [2:0] c4;
        logic       o5;
        logic [2:0] c5;
        logic       o8;
        logic [2:0] c8;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r,
                       input logic o4, input int c4,
                       input logic o5, input int c5,
                       input logic o8, input int c8);
        vec_t v;
        v.rst = r;
        v.o4 = o4; v.c4 = 3'(c4);
        v.o5 = o5; v.c5 = 3'(c5);
        v.o8 = o8; v.c8 = 3'(c8);
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    initial begin
        int first_rise;
        int h4, h5, h8;

        // Free run from power-up state (no reset edge seen).
        add(0, 0,1, 0,1, 0,1);
        add(0, 1,2, 0,2, 0,2);
        add(0, 1,3, 1,3, 0,3);
        add(0, 0,0, 1,4, 1,4);
        add(0, 0,1, 0,0, 1,5);
        add(0, 1,2, 0,1, 1,6);
        add(0, 1,3, 0,2, 1,7);
        add(0, 0,0, 1,3, 0,0);
        add(0, 0,1, 1,4, 0,1);
        add(0, 1,2, 0,0, 0,2);
        // Reset held for three edges.
        add(1, 0,0, 0,0, 0,0);
        add(1, 0,0, 0,0, 0,0);
        add(1, 0,0, 0,0, 0,0);
        // Release: rise at edge 2, fall at edge 4 for ratio 4.
        add(0, 0,1, 0,1, 0,1);
        add(0, 1,2, 0,2, 0,2);
        add(0, 1,3, 1,3, 0,3);
        add(0, 0,0, 1,4, 1,4);
        add(0, 0,1, 0,0, 1,5);
        add(0, 1,2, 0,1, 1,6);
        add(0, 1,3, 0,2, 1,7);
        add(0, 0,0, 1,3, 0,0);
        add(0, 0,1, 1,4, 0,1);
        add(0, 1,2, 0,0, 0,2);
        add(0, 1,3, 0,1, 0,3);
        // Mid-period reset while ratio-4 output is high.
        add(1, 0,0, 0,0, 0,0);
        add(0, 0,1, 0,1, 0,1);
        add(0, 1,2, 0,2, 0,2);
        add(0, 1,3, 1,3, 0,3);
        add(0, 0,0, 1,4, 1,4);

        reset = 1'b1;
        #1;
        chk("powerup_out4", {7'd0, out4}, 8'd0);
        chk("powerup_out5", {7'd0, out5}, 8'd0);
        chk("powerup_out8", {7'd0, out8}, 8'd0);
`ifdef CLOCK_DIVIDER_TICK_EN
        chk("powerup_tick", {7'd0, tick4}, 8'd0);
`endif
        reset = 1'b0;

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_out4", i), {7'd0, out4}, {7'd0, tbl[i].o4});
            chk($sformatf("v%0d_cnt4", i), {5'd0, dut4.cnt_q}, {5'd0, tbl[i].c4});
            chk($sformatf("v%0d_out5", i), {7'd0, out5}, {7'd0, tbl[i].o5});
            chk($sformatf("v%0d_cnt5", i), {5'd0, dut5.cnt_q}, {5'd0, tbl[i].c5});
            chk($sformatf("v%0d_out8", i), {7'd0, out8}, {7'd0, tbl[i].o8});
            chk($sformatf("v%0d_cnt8", i), {5'd0, dut8.cnt_q}, {5'd0, tbl[i].c8});
`ifdef CLOCK_DIVIDER_TICK_EN
            chk($sformatf("v%0d_tick", i), {7'd0, tick4},
                {7'd0, (!tbl[i].rst && tbl[i].c4 == 3'd2)});
`endif
        end

        // Bounded wait for first rise after a single-edge reset.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        first_rise = 0;
        for (int n = 1; n <= 10 && first_rise == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out4 === 1'b1) first_rise = n;
        end
        chk("first_rise_edge4", 8'(first_rise), 8'd2);

        // Count high cycles over a fixed window from reset.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        h4 = 0; h5 = 0; h8 = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            h4 += int'(out4 === 1'b1);
            h5 += int'(out5 === 1'b1);
            h8 += int'(out8 === 1'b1);
        end
        chk("high_cnt4", 8'(h4), 8'd5);
        chk("high_cnt5", 8'(h5), 8'd4);
        chk("high_cnt8", 8'(h8), 8'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
